// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared pixel and 3x3 window types for the kernel pipeline
package img_pkg;

    localparam int PIX_W = 4;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [2:0][2:0]  win3_t;

endpackage

// File: rtl/window_gen_3x3_line_ram.sv
// rtl/window_gen_3x3_line_ram.sv - single-port line buffer, combinational read, write on clock
module line_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read returns the old word in the write cycle, giving read-before-write
    assign rdata_o = mem_q[addr_i];

    // Write port; contents deliberately not reset (row gating masks stale data)
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - streaming 3x3 neighbourhood generator with two line buffers
module window_gen_3x3
    import img_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = img_pkg::PIX_W,
    localparam int CW   = $clog2(IMG_W),
    localparam int RW   = $clog2(IMG_H)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic                        in_sof,
    input  logic [PIX_W-1:0]            in_pixel,
    output logic [2:0][2:0][PIX_W-1:0]  win,
    output logic                        out_valid,
    output logic [CW-1:0]               out_x,
    output logic [RW-1:0]               out_y,
    output logic                        out_frame_done,
    output logic                        sof_err
);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d, eff_c;
    logic [RW-1:0] row_q, row_d, eff_r;
    logic [PIX_W-1:0] a0, a1;

    logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] out_x_q, out_x_d;
    logic [RW-1:0] out_y_q, out_y_d;
    logic          frame_done_q, frame_done_d;
    logic          sof_err_q, sof_err_d;

    // Line 0 holds row r-1, line 1 holds row r-2; line 1 is fed from line 0's old word
    line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk     (clk),
        .addr_i  (eff_c),
        .we_i    (in_valid),
        .wdata_i (in_pixel),
        .rdata_o (a0)
    );

    line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk     (clk),
        .addr_i  (eff_c),
        .we_i    (in_valid),
        .wdata_i (a0),
        .rdata_o (a1)
    );

    // Position of the pixel being accepted; start-of-frame forces (0,0)
    always_comb begin
        eff_c = in_sof ? '0 : col_q;
        eff_r = in_sof ? '0 : row_q;
    end

    // Next state: counters, window shift and output stage, all gated by acceptance
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        sof_err_d    = 1'b0;
        if (in_valid) begin
            if (eff_c == COL_LAST) begin
                col_d = '0;
                row_d = (eff_r == ROW_LAST) ? '0 : eff_r + RW'(1);
            end else begin
                col_d = eff_c + CW'(1);
                row_d = eff_r;
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2]  = a1;
            win_d[1][2]  = a0;
            win_d[2][2]  = in_pixel;
            out_x_d      = eff_c - CW'(1);
            out_y_d      = eff_r - RW'(1);
            out_valid_d  = (eff_r >= RW'(2)) && (eff_c >= CW'(2));
            frame_done_d = (eff_r == ROW_LAST) && (eff_c == COL_LAST);
            sof_err_d    = in_sof && ((col_q != '0) || (row_q != '0));
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

    assign win            = win_q;
    assign out_valid      = out_valid_q;
    assign out_x          = out_x_q;
    assign out_y          = out_y_q;
    assign out_frame_done = frame_done_q;
    assign sof_err        = sof_err_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb/tb_window_gen_3x3.sv - self-checking bench for window_gen_3x3
module tb_window_gen_3x3;
    import img_pkg::*;

    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    pix_t       in_pixel = '0;
    win3_t      win;
    logic       out_valid;
    logic [2:0] out_x;
    logic [1:0] out_y;
    logic       out_frame_done;
    logic       sof_err;

    window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(PIX_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_sof         (in_sof),
        .in_pixel       (in_pixel),
        .win            (win),
        .out_valid      (out_valid),
        .out_x          (out_x),
        .out_y          (out_y),
        .out_frame_done (out_frame_done),
        .sof_err        (sof_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: image of the current frame plus the raster position
    pix_t img [H][W];
    int   mr = 0;
    int   mc = 0;
    int   nwin = 0;
    int   nfd = 0;
    int   nse = 0;
    win3_t last_win;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic win3_t mkwin(input int v [9]);
        win3_t w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[r][c] = pix_t'(v[3*r+c]);
        return w;
    endfunction

    // One clock: drive inputs, predict from the model, check after the edge
    task automatic step(input bit v, input bit s, input pix_t p);
        bit    ev = 0;
        bit    efd = 0;
        bit    ese = 0;
        win3_t ew = '0;
        int    r = 0;
        int    c = 0;
        if (v) begin
            if (s) begin
                ese = (mr != 0) || (mc != 0);
                mr = 0;
                mc = 0;
            end
            r = mr;
            c = mc;
            img[r][c] = p;
            if (r >= 2 && c >= 2) begin
                ev = 1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew[i][j] = img[r-2+i][c-2+j];
            end
            efd = (r == H-1) && (c == W-1);
            mc++;
            if (mc == W) begin
                mc = 0;
                mr++;
                if (mr == H) mr = 0;
            end
        end
        in_valid = v;
        in_sof   = s;
        in_pixel = p;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        chk("out_valid", 64'(out_valid), 64'(ev));
        if (ev) begin
            chk("win", 64'(win), 64'(ew));
            chk("out_x", 64'(out_x), 64'(c - 1));
            chk("out_y", 64'(out_y), 64'(r - 1));
        end
        chk("out_frame_done", 64'(out_frame_done), 64'(efd));
        chk("sof_err", 64'(sof_err), 64'(ese));
        if (out_valid) begin
            nwin++;
            last_win = win;
        end
        if (out_frame_done) nfd++;
        if (sof_err) nse++;
    endtask

    task automatic pix(input bit s, input int gap_pct, input pix_t p);
        while ($urandom_range(99) < gap_pct) step(0, 0, '0);
        step(1, s, p);
    endtask

    task automatic frame(input bit sof_first, input int gap_pct);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                pix(sof_first && r == 0 && c == 0, gap_pct, pix_t'($urandom));
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mr = 0;
        mc = 0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_win", 64'(win), 64'd0);
        chk("rst_out_x", 64'(out_x), 64'd0);
        chk("rst_out_y", 64'(out_y), 64'd0);
        chk("rst_frame_done", 64'(out_frame_done), 64'd0);
        chk("rst_sof_err", 64'(sof_err), 64'd0);
    endtask

    initial begin
        int w0;
        int f0;
        int s0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Test 1/2: ramp frame, in_valid held high, directed window checks
        w0 = nwin;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1, r == 0 && c == 0, pix_t'((5*r + c) % 16));
                if (r == 2 && c == 2)
                    chk("first_win", 64'(win), 64'(mkwin('{0, 1, 2, 5, 6, 7, 10, 11, 12})));
                if (r == 3 && c == 2)
                    chk("wrap_win", 64'(win), 64'(mkwin('{5, 6, 7, 10, 11, 12, 15, 0, 1})));
            end
        end
        chk("t1_windows", 64'(nwin - w0), 64'd6);

        // Test 3: random pixels with ~50% gaps
        w0 = nwin;
        frame(1, 50);
        chk("t3_windows", 64'(nwin - w0), 64'd6);

        // Test 4: back-to-back frames with in_sof
        w0 = nwin;
        f0 = nfd;
        s0 = nse;
        frame(1, 0);
        frame(1, 0);
        chk("t4_windows", 64'(nwin - w0), 64'd12);
        chk("t4_frame_done", 64'(nfd - f0), 64'd2);
        chk("t4_sof_err", 64'(nse - s0), 64'd0);

        // Test 5: in_sof arriving at (1,3)
        f0 = nfd;
        s0 = nse;
        for (int i = 0; i < 8; i++) pix(0, 20, pix_t'($urandom));
        w0 = nwin;
        frame(1, 20);
        chk("t5_sof_err", 64'(nse - s0), 64'd1);
        chk("t5_frame_done", 64'(nfd - f0), 64'd1);
        chk("t5_windows", 64'(nwin - w0), 64'd6);

        // Test 6: reset after accepting (2,3), then a fresh frame
        for (int i = 0; i < 14; i++) pix(i == 0, 0, pix_t'($urandom));
        do_reset();
        w0 = nwin;
        step(0, 0, '0);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1, r == 0 && c == 0, pix_t'($urandom));
                if (r == 2 && c == 2) begin
                    chk("t6_first_x", 64'(out_x), 64'd1);
                    chk("t6_first_y", 64'(out_y), 64'd1);
                end
            end
        end
        chk("t6_windows", 64'(nwin - w0), 64'd6);

        // Random tail: frames without in_sof and random gaps
        for (int k = 0; k < 3; k++) frame(0, $urandom_range(60));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
